// File: rtl/radiant_event_trig_gen.sv
// ============================================================================
// Module  : radiant_event_trig_gen
// Brief   : Trigger arbiter and event sequencer; masks, holds off and limits
//           outstanding events, counting the triggers it has to drop.
// Revision: 1.0
// ============================================================================
`default_nettype none

module radiant_event_trig_gen #(
    parameter int MAX_PENDING = 15,
    parameter int HOLDOFF_W   = 16,
    parameter int DROP_W      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [3:0]           trig_mask_i,
    input  logic                 trig_ext_i,
    input  logic                 trig_rf_i,
    input  logic                 trig_pps_i,
    input  logic                 trig_soft_i,
    input  logic [HOLDOFF_W-1:0] holdoff_i,
    output logic                 digitize_start_o,
    input  logic                 digitize_done_i,
    output logic                 event_o,
    output logic                 event_type_o,
    output logic [31:0]          event_info_o,
    output logic                 event_done_o,
    input  logic                 readout_complete_i,
    output logic [4:0]           pending_o,
    output logic                 full_o,
    output logic                 busy_o,
    output logic [DROP_W-1:0]    dropped_o,
    input  logic                 dropped_clr_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIGI = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [4:0]           c_max_pending = 5'(MAX_PENDING);
    localparam logic [HOLDOFF_W-1:0] c_hold_one    = HOLDOFF_W'(1);
    localparam logic [DROP_W-1:0]    c_drop_one    = DROP_W'(1);

    state_t                r_state;
    logic [3:0]            r_trig_q;
    logic [HOLDOFF_W-1:0]  r_hold_cnt;
    logic [4:0]            r_pending;
    logic [DROP_W-1:0]     r_dropped;

    logic [3:0]            w_trig;
    logic [3:0]            w_edge;
    logic [3:0]            w_masked;
    logic                  w_hit;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_pend_dec;
    logic [1:0]            w_code;
    logic [15:0]           w_drop_lo;

    assign w_trig     = {trig_ext_i, trig_rf_i, trig_pps_i, trig_soft_i};
    assign w_edge     = w_trig & ~r_trig_q;
    assign w_masked   = w_edge & trig_mask_i;
    assign w_hit      = enable_i & (|w_masked);
    assign w_accept   = w_hit & ~full_o & (r_state == ST_IDLE);
    assign w_drop     = w_hit & ~w_accept;
    // An underflowing readout is discarded so the count never wraps.
    assign w_pend_dec = readout_complete_i & (r_pending != 5'd0);

    assign pending_o  = r_pending;
    assign full_o     = (r_pending == c_max_pending);
    assign busy_o     = (r_state != ST_IDLE);
    assign dropped_o  = r_dropped;

    always_comb begin
        w_code = 2'd0;
        if (w_masked[3])      w_code = 2'd3;
        else if (w_masked[2]) w_code = 2'd2;
        else if (w_masked[1]) w_code = 2'd1;
    end

    generate
        if (DROP_W >= 16) begin : g_drop_wide
            assign w_drop_lo = r_dropped[15:0];
        end else begin : g_drop_narrow
            assign w_drop_lo = {{(16-DROP_W){1'b0}}, r_dropped};
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_trig_q <= 4'd0;
        end else begin
            r_trig_q <= w_trig;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state          <= ST_IDLE;
            r_hold_cnt       <= '0;
            event_o          <= 1'b0;
            digitize_start_o <= 1'b0;
            event_type_o     <= 1'b0;
            event_info_o     <= 32'd0;
            event_done_o     <= 1'b0;
        end else begin
            event_o          <= 1'b0;
            digitize_start_o <= 1'b0;
            event_type_o     <= 1'b0;
            event_info_o     <= 32'd0;
            event_done_o     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        event_o          <= 1'b1;
                        digitize_start_o <= 1'b1;
                        event_type_o     <= (w_masked == 4'b0001);
                        event_info_o     <= {w_drop_lo, 10'd0, w_code, w_masked};
                        r_state          <= ST_DIGI;
                    end
                end
                ST_DIGI: begin
                    if (digitize_done_i) begin
                        event_done_o <= 1'b1;
                        r_hold_cnt   <= holdoff_i;
                        r_state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - c_hold_one;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pending <= 5'd0;
        end else begin
            case ({event_o, w_pend_dec})
                2'b10:   r_pending <= r_pending + 5'd1;
                2'b01:   r_pending <= r_pending - 5'd1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    // Clear wins over a same-cycle drop; the count sticks at all-ones.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_dropped <= '0;
        end else if (dropped_clr_i) begin
            r_dropped <= '0;
        end else if (w_drop && (r_dropped != '1)) begin
            r_dropped <= r_dropped + c_drop_one;
        end
    end

endmodule

`default_nettype wire

// File: doc/radiant_event_trig_gen.md
# radiant_event_trig_gen

Upstream event source for the event-control core, in the sysclk domain. Arbitrates trigger requests (external, RF, PPS, software) and applies the trigger mask, holdoff and a pending-event limit. Each accepted trigger produces the `event_o`/`event_type_o`/`event_info_o` strobe that captures the event header. The block then sequences digitization and issues `event_done_o` to queue the DMA request. Triggers that arrive while the block is busy or the pending limit is reached are counted as dropped.

## Interface
- `MAX_PENDING`, 15: max outstanding events; keeps the 16-deep header FIFOs from overflowing.
- `HOLDOFF_W`, 16: width of the holdoff counter.
- `DROP_W`, 16: width of the dropped-trigger counter.

- `clk_i`  in  1  sysclk; the only clock.
- `rst_i`  in  1  asynchronous, active-low reset (0 = reset).
- `enable_i`  in  1  global trigger enable.
- `trig_mask_i`  in  4  per-source enable, [3]=ext [2]=rf [1]=pps [0]=soft.
- `trig_ext_i`, `trig_rf_i`, `trig_pps_i`, `trig_soft_i`  in  1 each  trigger request levels; only rising edges are used.
- `holdoff_i`  in  HOLDOFF_W  dead cycles enforced after `event_done_o`.
- `digitize_start_o`  out  1  one-cycle pulse that starts digitization.
- `digitize_done_i`  in  1  one-cycle pulse when digitization finishes.
- `event_o`  out  1  one-cycle header-capture strobe.
- `event_type_o`  out  1  1 = software-forced event.
- `event_info_o`  out  32  header info word; valid while `event_o` is high.
- `event_done_o`  out  1  one-cycle pulse that queues the DMA request.
- `readout_complete_i`  in  1  one-cycle pulse; one event has been fully read out.
- `pending_o`  out  5  outstanding event count.
- `full_o`  out  1  `pending_o` == MAX_PENDING.
- `busy_o`  out  1  state ≠ IDLE.
- `dropped_o`  out  DROP_W  saturating count of dropped triggers.
- `dropped_clr_i`  in  1  synchronous clear of `dropped_o`.

## Operation
- Edge detection: each trigger input is registered; `edge[k] = trig[k] & ~trig_q[k]`.
- Masked edges: `m = edge & trig_mask_i`.
- State machine:
  - IDLE → DIGI: when `enable_i & |m & ~full_o`.
  - DIGI → HOLD: on `digitize_done_i`.
  - HOLD → IDLE: when the holdoff counter reaches 0. Holdoff of 0 returns to IDLE on the cycle after entering HOLD.
- Arbitration: the highest set bit of `m` wins. Code: ext=3, rf=2, pps=1, soft=0.
- `event_info_o` layout:
  - [3:0] = `m` in the accept cycle.
  - [5:4] = winner code.
  - [15:6] = 0.
  - [31:16] = `dropped_o[15:0]` in the accept cycle.
- `event_type_o` = 1 only when `m` == 4'b0001 (software alone).
- Drop counting: `dropped_o` increments by 1 per cycle with `enable_i & |m` when the trigger is not accepted (not IDLE, or `full_o`). It saturates at all-ones. `dropped_clr_i` takes priority over an increment in the same cycle.
- `enable_i` low: edges are ignored and not counted. An in-flight event still completes.
- Pending count:
  - +1 on `event_o`; −1 on `readout_complete_i`.
  - Both in the same cycle → unchanged.
  - `readout_complete_i` while the count is 0 → ignored.
  - Never exceeds MAX_PENDING, because accepts are gated by `full_o`.
- A `digitize_done_i` outside DIGI is ignored.
- Reset values: all outputs 0, state IDLE, all counters 0, `trig_q` 0. Reset asserted mid-event aborts immediately and no `event_done_o` is issued.

## Timing
- Edge sampled at cycle N → at N+1, `event_o`, `digitize_start_o`, `event_type_o` and `event_info_o` are all registered and high/valid for exactly one cycle.
- `pending_o` reflects the accept at N+2.
- `digitize_done_i` at cycle D → `event_done_o` at D+1. The holdoff counter loads `holdoff_i` at D+1.
- `busy_o` deasserts `holdoff_i`+1 cycles after `event_done_o`. The next trigger edge is accepted on the cycle `busy_o` is low.
- Minimum event period: 3 + digitize latency + `holdoff_i` cycles.

## Test plan
- **Single RF event:** mask=4'hF, rf edge at cycle 10, `digitize_done_i` at 20, holdoff=5 → `event_o`/`digitize_start_o` at 11, `event_info_o`=0x0000_0024, `event_type_o`=0, `event_done_o` at 21, `busy_o` low at 27, `pending_o`=1.
- **Simultaneous edges:** ext+soft in the same cycle, mask=4'hF → `info[3:0]`=4'b1001, winner=3, `type`=0. Soft alone → `info`=0x0000_0001, `type`=1.
- **Drops:** 4 rf edges during DIGI, plus 1 with `enable_i`=0 → `dropped_o`=4. The next accepted event has `info[31:16]`=4. Pulse `dropped_clr_i` together with a drop → `dropped_o`=0.
- **Full:** 15 events with no `readout_complete_i` → `full_o`=1 and the 16th edge is dropped. `readout_complete_i` on the same cycle as a new `event_o` → `pending_o` stays at 14. Underflow at 0 → `pending_o` stays 0.
- **Reset mid-event:** `rst_i` low during DIGI → all outputs 0 immediately. After release, a `digitize_done_i` produces no `event_done_o`, and a new edge is accepted normally.
- **Holdoff 0 and mask:** holdoff=0 → IDLE 1 cycle after `event_done_o`. With `trig_mask_i`=0, edges cause no event and no drop.
